mul_issue_ctrl: RTL and testbench

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

---
 rtl/mul_pkg.sv | 8 +
 rtl/mul_issue_ctrl.sv | 64 ++++++
 tb/tb_mul_issue_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM states and funct3 codes for the multiply issue controller
package mul_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
endpackage

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issues one multiply at a time to an external CE-pipelined multiplier and returns its result
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        mul_ce,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [2:0]  mul_funct3,
  input  logic [31:0] mul_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_rd,
  output logic        busy
);
  state_t state, state_nxt;
  logic [2:0] cnt;
  logic accept, legal, done;
  assign req_ready = !flush && (state == IDLE || (state == RESP && rsp_ready));
  assign accept = req_valid && req_ready;
  assign legal = !req_funct3[2];
  assign done = state == BUSY && cnt == 3'd0;
  assign mul_ce = state == BUSY;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  always_comb
    state_nxt = flush ? IDLE
              : accept ? (legal ? BUSY : RESP)
              : done ? RESP
              : (rsp_valid && rsp_ready) ? IDLE
              : state;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nxt;
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      mul_a <= '0;
      mul_b <= '0;
      mul_funct3 <= '0;
      rsp_result <= '0;
      rsp_rd <= '0;
    end else begin
      if (accept && legal) begin
        mul_a <= req_a;
        mul_b <= req_b;
        mul_funct3 <= req_funct3;
        cnt <= 3'(MUL_LAT - 1);
      end else if (mul_ce && !done) cnt <= cnt - 3'd1;
      if (accept) rsp_rd <= req_rd;
      if (accept && !legal) rsp_result <= '0;
      else if (done && !flush) rsp_result <= mul_result;
    end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed and randomized checks of mul_issue_ctrl against a transaction-level model
module tb_mul_issue_ctrl;
  import mul_pkg::*;
  localparam int L = 3;
  logic clk = 0, reset = 1, flush = 0, req_valid = 0, rsp_ready = 0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [4:0] req_rd = '0;
  logic req_ready, mul_ce, rsp_valid, busy;
  logic [31:0] mul_a, mul_b, mul_result, rsp_result;
  logic [2:0] mul_funct3;
  logic [4:0] rsp_rd;
  int n_cmp = 0, n_fail = 0, n_rsp = 0, cyc = 0, ce_cnt = 0, ready_at = 0;
  bit started = 0, post_rst = 0, have_op = 0;
  logic [31:0] e_res = '0, m_a = '0, m_b = '0;
  logic [4:0] e_rd = '0;
  logic [2:0] m_f = '0;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.MUL_LAT(L)) dut (
    .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .mul_ce(mul_ce), .mul_a(mul_a), .mul_b(mul_b), .mul_funct3(mul_funct3),
    .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_rd(rsp_rd), .busy(busy)
  );

  function automatic logic [31:0] mulf(input logic [31:0] a, b, input logic [2:0] f);
    logic [63:0] xa, xb, p;
    xa = {(f == MULH || f == MULHSU) ? {32{a[31]}} : 32'h0, a};
    xb = {(f == MULH) ? {32{b[31]}} : 32'h0, b};
    p = xa * xb;
    return f[2] ? 32'h0 : (f == MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hffffffff;
      2: return 32'h80000000;
      3: return 32'h7fffffff;
      default: return $urandom;
    endcase
  endfunction

  // external multiplier: result is only correct on the L-th consecutive CE cycle
  always @(posedge clk) ce_cnt <= mul_ce ? ce_cnt + 1 : 0;
  assign mul_result = (ce_cnt == L - 1) ? mulf(mul_a, mul_b, mul_funct3) : 32'hdeadbeef ^ 32'(ce_cnt);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // model: at most one operation outstanding, response due at a known cycle
  always @(posedge clk) begin : model
    bit ev, acc;
    ev = have_op && cyc >= ready_at;
    acc = req_valid && !flush && (!have_op || (ev && rsp_ready));
    if (reset) begin
      have_op = 0;
      post_rst = 1;
      started = 1;
    end else begin
      post_rst = 0;
      if (ev && rsp_ready && !flush) n_rsp++;
      if (flush || (ev && rsp_ready)) have_op = 0;
      if (acc) begin
        have_op = 1;
        ready_at = cyc + 1 + (req_funct3[2] ? 0 : L);
        e_rd = req_rd;
        e_res = mulf(req_a, req_b, req_funct3);
        if (!req_funct3[2]) begin
          m_a = req_a;
          m_b = req_b;
          m_f = req_funct3;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) if (started) begin : compare
    bit ev, ce;
    ev = have_op && cyc >= ready_at;
    ce = have_op && cyc < ready_at;
    chk("req_ready", 32'(req_ready), 32'(!flush && (!have_op || (ev && rsp_ready))));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(have_op));
    chk("mul_ce", 32'(mul_ce), 32'(ce));
    if (ev) begin
      chk("rsp_result", rsp_result, e_res);
      chk("rsp_rd", 32'(rsp_rd), 32'(e_rd));
    end
    if (ce) begin
      chk("mul_a", mul_a, m_a);
      chk("mul_b", mul_b, m_b);
      chk("mul_funct3", 32'(mul_funct3), 32'(m_f));
    end
    if (post_rst) begin
      chk("rst_rsp_result", rsp_result, 32'h0);
      chk("rst_rsp_rd", 32'(rsp_rd), 32'h0);
      chk("rst_mul_a", mul_a, 32'h0);
      chk("rst_mul_b", mul_b, 32'h0);
      chk("rst_mul_funct3", 32'(mul_funct3), 32'h0);
    end
  end

  task automatic op(input logic [31:0] a, b, input logic [2:0] f, input logic [4:0] rd,
                    input logic [31:0] er, input int el, input int ece, input int hold, input string nm);
    int k, ce_n;
    @(posedge clk); #1;
    req_valid = 1; req_a = a; req_b = b; req_funct3 = f; req_rd = rd; rsp_ready = 0; flush = 0;
    @(posedge clk); #1;
    req_valid = 0;
    k = 1;
    ce_n = 0;
    while (!rsp_valid && k < 20) begin
      ce_n += int'(mul_ce);
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_lat"}, k, el);
    chk({nm, "_ce_cycles"}, ce_n, ece);
    chk({nm, "_res"}, rsp_result, er);
    chk({nm, "_rd"}, 32'(rsp_rd), 32'(rd));
    repeat (hold) begin
      @(posedge clk); #1;
    end
    chk({nm, "_held_valid"}, {29'h0, rsp_valid, req_ready, mul_ce}, 32'h4);
    chk({nm, "_held_res"}, rsp_result, er);
    chk({nm, "_held_rd"}, 32'(rsp_rd), 32'(rd));
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk({nm, "_done_idle"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    op(32'd7, 32'd6, MUL, 5'd5, 32'd42, L + 1, L, 1, "mul");
    op(32'h80000000, 32'h80000000, MULH, 5'd9, 32'h40000000, L + 1, L, 5, "mulh");
    op(32'hffffffff, 32'hffffffff, MULHU, 5'd31, 32'hfffffffe, L + 1, L, 1, "mulhu");
    op(32'hfffffffd, 32'd5, MULHSU, 5'd1, 32'hffffffff, L + 1, L, 1, "mulhsu");
    op(32'd123, 32'd456, 3'b101, 5'd3, 32'h0, 1, 0, 1, "illegal");
    // back-to-back: second request taken on the first response's handshake
    @(posedge clk); #1;
    req_valid = 1; req_a = 2; req_b = 3; req_funct3 = MUL; req_rd = 1; rsp_ready = 1;
    @(posedge clk); #1;
    req_a = 4; req_b = 5; req_rd = 2;
    k = 1;
    while (!rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
    chk("b2b_first_res", rsp_result, 32'd6);
    chk("b2b_same_cycle_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 0;
    k = 1;
    while (!rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
    chk("b2b_gap", k, L + 1);
    chk("b2b_second_res", rsp_result, 32'd20);
    chk("b2b_second_rd", 32'(rsp_rd), 32'd2);
    @(posedge clk); #1;
    rsp_ready = 0;
    // flush on the second busy cycle with a request offered
    @(posedge clk); #1;
    req_valid = 1; req_a = 9; req_b = 9; req_funct3 = MUL; req_rd = 4;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    flush = 1; req_valid = 1; req_rd = 6;
    chk("flush_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    flush = 0; req_valid = 0;
    chk("flush_idle", {30'h0, busy, rsp_valid}, 32'h0);
    k = 0;
    repeat (L + 3) begin @(posedge clk); #1; k += int'(rsp_valid); end
    chk("flush_no_rsp", k, 0);
    // reset in the middle of an operation
    @(posedge clk); #1;
    req_valid = 1; req_a = 32'hffffffff; req_b = 3; req_funct3 = MULHU; req_rd = 17;
    @(posedge clk); #1;
    req_valid = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("rstb_flags", {28'h0, mul_ce, busy, rsp_valid, req_ready}, 32'h1);
    chk("rstb_res", rsp_result, 32'h0);
    chk("rstb_rd", 32'(rsp_rd), 32'h0);
    chk("rstb_ops", mul_a | mul_b | 32'(mul_funct3), 32'h0);
    k = 0;
    repeat (L + 3) begin @(posedge clk); #1; k += int'(rsp_valid); end
    chk("rstb_no_rsp", k, 0);
    n_rsp = 0;
    repeat (3000) begin
      @(posedge clk); #1;
      reset = $urandom_range(0, 299) == 0;
      flush = $urandom_range(0, 29) == 0;
      req_valid = $urandom_range(0, 3) != 0;
      req_funct3 = $urandom_range(0, 9) == 0 ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
      req_a = pick();
      req_b = pick();
      req_rd = 5'($urandom);
      rsp_ready = $urandom_range(0, 9) < 7;
    end
    @(posedge clk); #1;
    reset = 0; flush = 0; req_valid = 0; rsp_ready = 1;
    repeat (L + 3) @(posedge clk);
    #1;
    chk("random_rsp_seen", 32'(n_rsp > 50), 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
